mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Memory-side partner of the CPU top: consumes the two packed cache-miss ports and serves them over one byte-wide RAM bus.
  - Slot 0 = DCACHE, bits [31:0] / [3:0] / [1:0].
  - Slot 1 = ICACHE, bits [63:32] / [7:4] / [3:2].
- Arbitrates between the slots, splits each 32-bit access into four little-endian byte cycles, and returns busy/done to the caches.

Parameters:
- RAM_ADDR_WIDTH, 17, width of ram_addr_o; request address bits above this are ignored.
- RD_LATENCY, 1, cycles from ram_en_o (read) to valid ram_r_data_i; only value 1 is required.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-low reset; rst==0 at a rising edge resets.
- mem_rw_flag_i  in  4  per slot {write, read}; 2'b11 is treated as write.
- mem_addr_i  in  64  per-slot byte address.
- mem_r_data_o  out  64  per-slot read word.
- mem_w_data_i  in  64  per-slot write word.
- mem_w_mask_i  in  8  per-slot byte-enable mask.
- mem_busy_o  out  2  per-slot, high while that slot is being served.
- mem_done_o  out  2  per-slot, one-cycle completion pulse.
- ram_en_o  out  1  RAM byte access strobe.
- ram_we_o  out  1  1 = write, 0 = read.
- ram_addr_o  out  RAM_ADDR_WIDTH  byte address.
- ram_w_data_o  out  8  write byte.
- ram_r_data_i  in  8  read byte, valid one cycle after a read strobe.

Behaviour:
- Reset (rst==0):
  - State goes to IDLE; counter = 0.
  - All outputs = 0, including mem_r_data_o.
  - An in-flight transaction is dropped and no done is issued.
- States: IDLE, RD, WR, DONE. A 3-bit byte counter cnt is used in RD and WR.
- IDLE:
  - Each cycle, sample mem_rw_flag_i. Slot 0 has fixed priority over slot 1.
  - On a nonzero flag, latch slot id, address, w_data, w_mask and op. Go to RD (read) or WR (write) with cnt = 0.
  - ram_en_o = 0 and busy = 0 while in IDLE.
- RD (cnt 0..4):
  - cnt 0..3: ram_en_o = 1, ram_we_o = 0, ram_addr_o = addr + cnt.
  - cnt 1..4: capture ram_r_data_i into byte (cnt-1) of the word buffer.
  - cnt 4: ram_en_o = 0; go to DONE.
- WR (cnt 0..3):
  - ram_addr_o = addr + cnt, ram_w_data_o = w_data[8*cnt+7 : 8*cnt], ram_we_o = 1.
  - ram_en_o = w_mask[cnt]. Masked-off bytes still consume their cycle.
  - cnt 3: go to DONE.
- DONE (exactly 1 cycle):
  - mem_done_o[slot] = 1.
  - On a read, mem_r_data_o[slot] is updated at entry to DONE and stays stable until that slot's next read completes. Writes never change it; the other slot's word is untouched.
  - Requests are ignored in this cycle, which gives the cache one cycle to drop its flag. Next state is IDLE.
- mem_busy_o[slot] = 1 in RD, WR and DONE for the served slot only; the waiting slot sees busy = 0.
- Timing, with the request sampled in IDLE at cycle T:
  - Read: done at T+6, next sample at T+7.
  - Write: done at T+5, next sample at T+6.
- Address arithmetic: addr + cnt computed in RAM_ADDR_WIDTH bits and wraps modulo 2^RAM_ADDR_WIDTH. Unaligned addresses are legal.
- Byte order: little-endian; byte k sits at addr+k and maps to word bits [8k+7:8k].
- Flags changing mid-transaction have no effect; all request fields are latched.
- Starvation of slot 1 under continuous slot 0 traffic is accepted by design.

Decomposition:
- Shared package holds:
  - state encoding (IDLE/RD/WR/DONE);
  - slot indices SLOT_D = 0, SLOT_I = 1;
  - rw_flag bit positions (READ_BIT = 0, WRITE_BIT = 1).
- Single module; no sub-module needed. Slot unpacking is plain part-selects.

Test Plan:
- Read slot 1, addr 0x0000_1000, RAM holds bytes 13,00,00,00 at 0x1000..0x1003:
  - ram_addr_o steps 0x1000..0x1003 on T+1..T+4;
  - mem_done_o = 2'b10 only at T+6;
  - mem_r_data_o[63:32] = 0x0000_0013; mem_r_data_o[31:0] unchanged.
- Write slot 0, addr 0x20, data 0xAABBCCDD, mask 4'b0101:
  - ram_en_o high only at cnt 0 (0x20, 0xDD) and cnt 2 (0x22, 0xBB);
  - done[0] at T+5; subsequent read of 0x20 returns 0x00BB00DD over a zeroed RAM.
- Both slots request read in the same cycle:
  - slot 0 is served first, busy = 2'b01;
  - slot 1 is accepted on the first IDLE cycle after slot 0's DONE; each done pulse lasts exactly 1 cycle.
- Requester holds its flag through the DONE cycle and drops it the cycle after:
  - exactly one transaction occurs, with no duplicate access.
- Read at addr 0x1FFFF (RAM_ADDR_WIDTH = 17):
  - ram_addr_o sequence is 0x1FFFF, 0x00000, 0x00001, 0x00002.
- Reset asserted at WR cnt 1:
  - next cycle state is IDLE, all outputs 0, and no done is ever pulsed for the aborted request.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-slot cache-miss arbiter: FSM states, slot ids
// and the {write, read} flag bit positions.
package mem_arbiter_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_DONE} state_t;

  localparam logic SLOT_D    = 1'b0;
  localparam logic SLOT_I    = 1'b1;
  localparam int   READ_BIT  = 0;
  localparam int   WRITE_BIT = 1;
endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side packed miss ports plus the byte-wide RAM bus, bundled together.
interface mem_arbiter_if #(parameter int RAM_ADDR_WIDTH = 17);
  logic [3:0]                mem_rw_flag_i;
  logic [63:0]               mem_addr_i;
  logic [63:0]               mem_r_data_o;
  logic [63:0]               mem_w_data_i;
  logic [7:0]                mem_w_mask_i;
  logic [1:0]                mem_busy_o;
  logic [1:0]                mem_done_o;
  logic                      ram_en_o;
  logic                      ram_we_o;
  logic [RAM_ADDR_WIDTH-1:0] ram_addr_o;
  logic [7:0]                ram_w_data_o;
  logic [7:0]                ram_r_data_i;

  modport slave (
    input  mem_rw_flag_i, mem_addr_i, mem_w_data_i, mem_w_mask_i, ram_r_data_i,
    output mem_r_data_o, mem_busy_o, mem_done_o,
    output ram_en_o, ram_we_o, ram_addr_o, ram_w_data_o
  );

  modport master (
    output mem_rw_flag_i, mem_addr_i, mem_w_data_i, mem_w_mask_i, ram_r_data_i,
    input  mem_r_data_o, mem_busy_o, mem_done_o,
    input  ram_en_o, ram_we_o, ram_addr_o, ram_w_data_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Serves the DCACHE (slot 0, priority) and ICACHE (slot 1) miss ports over a
// byte-wide RAM: each 32-bit access becomes four little-endian byte cycles.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RAM_ADDR_WIDTH = 17,
  parameter int RD_LATENCY     = 1
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);
  localparam int         AW      = RAM_ADDR_WIDTH;
  localparam logic [2:0] RD_LAST = 3'(3 + RD_LATENCY);

  state_t           r_state;
  logic [2:0]       r_cnt;
  logic             r_slot;
  logic [AW-1:0]    r_base;
  logic [31:0]      r_wdata;
  logic [3:0]       r_mask;
  logic [23:0]      r_buf;
  logic [1:0][31:0] r_rdata;
  logic [1:0]       r_busy;
  logic [1:0]       r_done;
  logic             r_ram_en;
  logic             r_ram_we;
  logic [AW-1:0]    r_ram_addr;
  logic [7:0]       r_ram_wdata;

  logic [1:0][1:0]  w_flag;
  logic [1:0][31:0] w_addr;
  logic [1:0][31:0] w_wdata;
  logic [1:0][3:0]  w_mask;
  logic             w_req_d;
  logic             w_req_i;
  logic             w_sel;
  logic [2:0]       w_nxt;
  logic [AW-1:0]    w_nxt_addr;
  logic [1:0]       w_cap_idx;

  assign w_flag     = bus.mem_rw_flag_i;
  assign w_addr     = bus.mem_addr_i;
  assign w_wdata    = bus.mem_w_data_i;
  assign w_mask     = bus.mem_w_mask_i;
  assign w_req_d    = w_flag[SLOT_D][READ_BIT] | w_flag[SLOT_D][WRITE_BIT];
  assign w_req_i    = w_flag[SLOT_I][READ_BIT] | w_flag[SLOT_I][WRITE_BIT];
  assign w_sel      = w_req_d ? SLOT_D : SLOT_I;
  assign w_nxt      = r_cnt + 3'd1;
  assign w_nxt_addr = r_base + AW'(w_nxt);
  assign w_cap_idx  = 2'(r_cnt - 3'(RD_LATENCY));

  // Request address bits above the RAM width are intentionally dropped.
  if (AW < 32) begin : g_unused
    logic w_unused_addr;
    assign w_unused_addr = ^{w_addr[1][31:AW], w_addr[0][31:AW]};
  end

  // Outputs are registered: each branch loads what the next cycle presents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_slot      <= 1'b0;
      r_base      <= '0;
      r_wdata     <= '0;
      r_mask      <= '0;
      r_buf       <= '0;
      r_rdata     <= '0;
      r_busy      <= '0;
      r_done      <= '0;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req_d || w_req_i) begin
            r_slot         <= w_sel;
            r_base         <= w_addr[w_sel][AW-1:0];
            r_wdata        <= w_wdata[w_sel];
            r_mask         <= w_mask[w_sel];
            r_cnt          <= '0;
            r_busy[w_sel]  <= 1'b1;
            r_ram_addr     <= w_addr[w_sel][AW-1:0];
            // 2'b11 resolves to a write.
            if (w_flag[w_sel][WRITE_BIT]) begin
              r_state     <= ST_WR;
              r_ram_en    <= w_mask[w_sel][0];
              r_ram_we    <= 1'b1;
              r_ram_wdata <= w_wdata[w_sel][7:0];
            end else begin
              r_state     <= ST_RD;
              r_ram_en    <= 1'b1;
              r_ram_we    <= 1'b0;
            end
          end
        end
        ST_RD: begin
          if (r_cnt == RD_LAST) begin
            r_rdata[r_slot] <= {bus.ram_r_data_i, r_buf};
            r_done[r_slot]  <= 1'b1;
            r_state         <= ST_DONE;
            r_ram_en        <= 1'b0;
            r_ram_addr      <= '0;
          end else begin
            if (r_cnt >= 3'(RD_LATENCY))
              r_buf[8*w_cap_idx +: 8] <= bus.ram_r_data_i;
            r_cnt      <= w_nxt;
            r_ram_en   <= (w_nxt <= 3'd3);
            r_ram_addr <= (w_nxt <= 3'd3) ? w_nxt_addr : '0;
          end
        end
        ST_WR: begin
          if (r_cnt == 3'd3) begin
            r_done[r_slot] <= 1'b1;
            r_state        <= ST_DONE;
            r_ram_en       <= 1'b0;
            r_ram_we       <= 1'b0;
            r_ram_addr     <= '0;
            r_ram_wdata    <= '0;
          end else begin
            r_cnt       <= w_nxt;
            r_ram_en    <= r_mask[w_nxt[1:0]];
            r_ram_addr  <= w_nxt_addr;
            r_ram_wdata <= r_wdata[8*w_nxt[1:0] +: 8];
          end
        end
        ST_DONE: begin
          r_done  <= '0;
          r_busy  <= '0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_r_data_o = r_rdata;
  assign bus.mem_busy_o   = r_busy;
  assign bus.mem_done_o   = r_done;
  assign bus.ram_en_o     = r_ram_en;
  assign bus.ram_we_o     = r_ram_we;
  assign bus.ram_addr_o   = r_ram_addr;
  assign bus.ram_w_data_o = r_ram_wdata;
endmodule
